// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: validates NEC frames from the IR reader, offers commands over valid/ready,
// clears the reader and recovers it on inactivity. Repeat detection is built when IR_CMD_CTRL_REPEAT_EN is defined.
`timescale 1ns/1ps
module ir_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1200,
  parameter int unsigned RPT_WINDOW  = 1100,
  parameter int unsigned CLR_CYC     = 2
) (
  input  logic        IR_READER_CLK,
  input  logic        reset_n,
  input  logic        ir_signal,
  input  logic        rdr_avail,
  input  logic [31:0] rdr_data,
  output logic        rdr_reset,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [7:0]  cmd_code,
  output logic        cmd_repeat,
  output logic        err_frame,
  output logic        err_timeout,
  output logic        busy
);

  localparam int unsigned ACT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int unsigned RPT_W = $clog2(RPT_WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_OFFER = 2'd2
  } state_t;

  state_t           state;
  logic             ir_s1;
  logic             ir_s2;
  logic             act_seen;
  logic [ACT_W-1:0] act_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic             no_offer;
  logic [31:0]      frame_q;
  logic             rdr_reset_q;
  logic             frame_ok_c;
  logic             is_rpt_c;

  // Frame is valid when both bytes are followed by their exact complement
  assign frame_ok_c = ((frame_q[31:24] ^ frame_q[23:16]) == 8'hFF) &&
                      ((frame_q[15:8]  ^ frame_q[7:0])   == 8'hFF);

  // Reader is held in reset for as long as we are, so no stale frame survives
  assign rdr_reset = rdr_reset_q | ~reset_n;

  always_ff @(posedge IR_READER_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ir_s1       <= 1'b0;
      ir_s2       <= 1'b0;
      act_seen    <= 1'b0;
      act_cnt     <= '0;
      clr_cnt     <= '0;
      no_offer    <= 1'b0;
      frame_q     <= '0;
      rdr_reset_q <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_code    <= '0;
      cmd_repeat  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ir_s1       <= ir_signal;
      ir_s2       <= ir_s1;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // Capture takes priority over a coincident timeout terminal count
          if (rdr_avail) begin
            frame_q     <= rdr_data;
            act_seen    <= 1'b0;
            act_cnt     <= '0;
            no_offer    <= 1'b0;
            clr_cnt     <= '0;
            rdr_reset_q <= 1'b1;
            busy        <= 1'b1;
            state       <= S_CLEAR;
          end else if (act_cnt == ACT_W'(TIMEOUT_CYC)) begin
            err_timeout <= 1'b1;
            act_seen    <= 1'b0;
            act_cnt     <= '0;
            no_offer    <= 1'b1;
            clr_cnt     <= '0;
            rdr_reset_q <= 1'b1;
            busy        <= 1'b1;
            state       <= S_CLEAR;
          end else begin
            if (ir_s2) begin
              act_seen <= 1'b1;
            end
            if (act_seen || ir_s2) begin
              act_cnt <= act_cnt + ACT_W'(1);
            end
          end
        end

        S_CLEAR: begin
          if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
            rdr_reset_q <= 1'b0;
            if (no_offer) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (frame_ok_c) begin
              cmd_valid  <= 1'b1;
              cmd_addr   <= frame_q[31:24];
              cmd_code   <= frame_q[15:8];
              cmd_repeat <= is_rpt_c;
              state      <= S_OFFER;
            end else begin
              err_frame <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end

        S_OFFER: begin
          // rdr_avail is ignored here; the full reader simply waits for us
          if (cmd_ready) begin
            cmd_valid  <= 1'b0;
            cmd_repeat <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          rdr_reset_q <= 1'b0;
          cmd_valid   <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IR_CMD_CTRL_REPEAT_EN
  logic             xfer_c;
  logic             hist_vld;
  logic [7:0]       hist_addr;
  logic [7:0]       hist_code;
  logic [RPT_W-1:0] rpt_cnt;

  assign xfer_c = cmd_valid & cmd_ready;

  // History of the last delivered command and a saturating age counter
  always_ff @(posedge IR_READER_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hist_vld  <= 1'b0;
      hist_addr <= '0;
      hist_code <= '0;
      rpt_cnt   <= '0;
    end else if (xfer_c) begin
      hist_vld  <= 1'b1;
      hist_addr <= cmd_addr;
      hist_code <= cmd_code;
      rpt_cnt   <= '0;
    end else if (rpt_cnt != RPT_W'(RPT_WINDOW)) begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  assign is_rpt_c = hist_vld &&
                    (frame_q[31:24] == hist_addr) &&
                    (frame_q[15:8]  == hist_code) &&
                    (rpt_cnt < RPT_W'(RPT_WINDOW));
`else
  assign is_rpt_c = 1'b0;
`endif

endmodule
